// File: rtl/pattern_monitor_pkg.sv
// pattern_monitor_pkg: shared state type, default thresholds and rotate helper
package pattern_monitor_pkg;
  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} mon_state_t;
  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_LOSS_COUNT = 3;
  function automatic logic [7:0] rotl8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction
endpackage

// File: rtl/pattern_monitor_rot_tracker.sv
// rot_tracker: holds last sample of one bus and flags a miss against its left rotation
module rot_tracker #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [WIDTH-1:0] d,
  output logic             mismatch
);
  logic [WIDTH-1:0] prev_q, prev_d;
  // every strobed sample becomes the new reference, good or bad
  always_comb prev_d = valid ? d : prev_q;
  // reference register
  always_ff @(posedge clk) prev_q <= reset ? '0 : prev_d;
  assign mismatch = d != {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
endmodule

// File: rtl/pattern_monitor.sv
// pattern_monitor: lock/loss FSM and saturating error counter over two rotating buses
module pattern_monitor
  import pattern_monitor_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int LOSS_COUNT = DEF_LOSS_COUNT,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid,
  input  logic [WIDTH-1:0]   d1,
  input  logic [WIDTH-1:0]   d2,
  input  logic               clr,
  output logic               locked,
  output logic               mismatch1,
  output logic               mismatch2,
  output logic               err_pulse,
  output logic [COUNT_W-1:0] err_count
);
  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(LOSS_COUNT + 1);
  mon_state_t state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic [MW-1:0] miss_q, miss_d;
  logic mismatch1_q, mismatch1_d, mismatch2_q, mismatch2_d, err_pulse_q, err_pulse_d;
  logic [COUNT_W-1:0] err_count_q, err_count_d;
  logic mm1, mm2, bad;
  rot_tracker #(.WIDTH(WIDTH)) u_trk1 (.clk(clk), .reset(reset), .valid(valid), .d(d1), .mismatch(mm1));
  rot_tracker #(.WIDTH(WIDTH)) u_trk2 (.clk(clk), .reset(reset), .valid(valid), .d(d2), .mismatch(mm2));
  assign bad = mm1 | mm2;
  // next-state: IDLE only primes the trackers, SEARCH counts good runs, LOCKED counts misses
  always_comb begin
    state_d = state_q;
    run_d = run_q;
    miss_d = miss_q;
    mismatch1_d = mismatch1_q;
    mismatch2_d = mismatch2_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    if (valid) begin
      mismatch1_d = (state_q != IDLE) && mm1;
      mismatch2_d = (state_q != IDLE) && mm2;
      if (state_q == IDLE) begin
        state_d = SEARCH;
        run_d = '0;
      end else if (state_q == SEARCH) begin
        run_d = bad ? '0 : run_q + 1'b1;
        if (!bad && int'(run_q) + 1 == LOCK_COUNT) begin
          state_d = LOCKED;
          run_d = '0;
          miss_d = '0;
        end
      end else begin
        miss_d = bad ? miss_q + 1'b1 : '0;
        err_pulse_d = bad;
        if (bad) err_count_d = &err_count_q ? err_count_q : err_count_q + 1'b1;
        if (bad && int'(miss_q) + 1 == LOSS_COUNT) begin
          state_d = SEARCH;
          run_d = '0;
        end
      end
    end
    if (clr) err_count_d = '0;
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      run_q <= '0;
      miss_q <= '0;
      mismatch1_q <= 1'b0;
      mismatch2_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      run_q <= run_d;
      miss_q <= miss_d;
      mismatch1_q <= mismatch1_d;
      mismatch2_q <= mismatch2_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end
  assign locked = state_q == LOCKED;
  assign mismatch1 = mismatch1_q;
  assign mismatch2 = mismatch2_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
endmodule
